pc: RTL and testbench

PC -- requirements
Module: pc

---
 rtl/pc.sv | 58 +++++
 tb/tb_pc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc.sv
// pc: 32-bit program counter with sequential, absolute-jump and
// PC-relative-jump update paths.
// Optional feature macro: PC_ALIGN_EN -- when defined, bits [1:0] of every
// value loaded into the register are forced to zero. The port list is the
// same in both builds.
module pc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] STEP         = 32'd4
) (
    input  logic        clk,
    input  logic        rst,    // asynchronous, active-low
    input  logic        jmp,
    input  logic        rel,
    input  logic [31:0] nxt,
    input  logic [31:0] diff,
    output logic [31:0] cur
);

    logic [31:0] cur_q;
    logic [31:0] cur_d;
    logic [31:0] sel;

    // Choose the next PC: a jump replaces the sequential increment.
    // rel/nxt/diff are only looked at under jmp, so X on them cannot
    // leak into the register while jmp=0. Adds wrap modulo 2^32.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel   = cur_q + STEP;
        cur_d = sel;
        if (jmp) begin
            if (rel) begin
                sel = cur_q + diff;
            end else begin
                sel = nxt;
            end
        end
`ifdef PC_ALIGN_EN
        cur_d = {sel[31:2], 2'b00};
`else
        cur_d = sel;
`endif
    end

    // PC register; reset is asynchronous so cur shows RESET_VECTOR at once.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            cur_q <= RESET_VECTOR;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign cur = cur_q;

endmodule

// File: tb/tb_pc.sv
// tb_pc: directed self-checking bench for pc. Inputs change 1ns after a
// rising edge; cur is sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_pc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jmp = 1'b0;
    logic        rel = 1'b0;
    logic [31:0] nxt = 32'h0;
    logic [31:0] diff = 32'h0;
    logic [31:0] cur;

    int n_cmp = 0;
    int n_bad = 0;

    pc dut (
        .clk  (clk),
        .rst  (rst),
        .jmp  (jmp),
        .rel  (rel),
        .nxt  (nxt),
        .diff (diff),
        .cur  (cur)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (cur !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_immediate: got %h want %h", cur, 32'h0);
        end
        step();
        n_cmp++;
        if (cur !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_held: got %h want %h", cur, 32'h0);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_tbl [6];
        exp_tbl = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
        rst = 1'b1;
        jmp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (cur !== exp_tbl[i]) begin
                n_bad++;
                $display("FAIL free_run[%0d]: got %h want %h", i, cur, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_abs_jump();
        logic [31:0] exp_tbl [5];
        exp_tbl = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};
        jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_1000; diff = 32'h0000_0123;
        step();
        n_cmp++;
        if (cur !== 32'h1000) begin
            n_bad++;
            $display("FAIL abs_jump: got %h want %h", cur, 32'h1000);
        end
        jmp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (cur !== exp_tbl[i]) begin
                n_bad++;
                $display("FAIL abs_after[%0d]: got %h want %h", i, cur, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_rel_jump();
        jmp = 1'b1; rel = 1'b1; diff = 32'hFFFF_FFEC; nxt = 32'hDEAD_0000;
        step();
        n_cmp++;
        if (cur !== 32'h1000) begin
            n_bad++;
            $display("FAIL rel_jump: got %h want %h", cur, 32'h1000);
        end
        jmp = 1'b0;
        step();
        n_cmp++;
        if (cur !== 32'h1004) begin
            n_bad++;
            $display("FAIL rel_after: got %h want %h", cur, 32'h1004);
        end
        rel = 1'bx; nxt = 'x; diff = 'x;
        step();
        n_cmp++;
        if (cur !== 32'h1008) begin
            n_bad++;
            $display("FAIL x_ignored: got %h want %h", cur, 32'h1008);
        end
        rel = 1'b0; nxt = 32'h0; diff = 32'h0;
    endtask

    task automatic test_wrap();
        jmp = 1'b1; rel = 1'b0; nxt = 32'hFFFF_FFFC; diff = 32'h0000_0100;
        step();
        n_cmp++;
        if (cur !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_abs: got %h want %h", cur, 32'hFFFF_FFFC);
        end
        jmp = 1'b0;
        step();
        n_cmp++;
        if (cur !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_seq: got %h want %h", cur, 32'h0);
        end
        step();
        n_cmp++;
        if (cur !== 32'h4) begin
            n_bad++;
            $display("FAIL wrap_seq2: got %h want %h", cur, 32'h4);
        end
        jmp = 1'b1; rel = 1'b1; diff = 32'hFFFF_FFF8; nxt = 32'h0000_5550;
        step();
        n_cmp++;
        if (cur !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_rel: got %h want %h", cur, 32'hFFFF_FFFC);
        end
        jmp = 1'b0; rel = 1'b0;
    endtask

    task automatic test_async_reset();
        jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_1008;
        step();
        jmp = 1'b0;
        n_cmp++;
        if (cur !== 32'h1008) begin
            n_bad++;
            $display("FAIL pre_async: got %h want %h", cur, 32'h1008);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (cur !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h", cur, 32'h0);
        end
        jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_2000;
        step();
        n_cmp++;
        if (cur !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_over_jump: got %h want %h", cur, 32'h0);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (cur !== 32'h2000) begin
            n_bad++;
            $display("FAIL release_jump: got %h want %h", cur, 32'h2000);
        end
        jmp = 1'b0;
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (cur !== 32'h4) begin
            n_bad++;
            $display("FAIL release_seq: got %h want %h", cur, 32'h4);
        end
    endtask

    task automatic test_align();
        logic [31:0] exp_jump;
        logic [31:0] exp_next;
`ifdef PC_ALIGN_EN
        exp_jump = 32'h1000;
        exp_next = 32'h1004;
`else
        exp_jump = 32'h1003;
        exp_next = 32'h1007;
`endif
        jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_1003;
        step();
        n_cmp++;
        if (cur !== exp_jump) begin
            n_bad++;
            $display("FAIL align_jump: got %h want %h", cur, exp_jump);
        end
        jmp = 1'b0;
        step();
        n_cmp++;
        if (cur !== exp_next) begin
            n_bad++;
            $display("FAIL align_seq: got %h want %h", cur, exp_next);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_abs_jump();
        test_rel_jump();
        test_wrap();
        test_async_reset();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
